// File: rtl/simon_axi_fifo_bridge.sv
// ---------------------------------------------------------------------------
// simon_axi_fifo_bridge
//
// Purpose: an AXI slave with ID support and no addressing. Bridges AXI write
// bursts into an ingress FIFO, which the core side drains. Bridges an egress
// FIFO, which the core side fills, into AXI read bursts. The write path and
// the read path run independently. The address is a don't-care, so the AW
// and AR channels carry only an ID and a burst length.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   aw*                 write address: awid, awlen, awvalid/awready
//   w*                  write data: wdata, wstrb, wlast, wvalid/wready
//   b*                  write response: bid, bresp, bvalid/bready
//   ar*                 read address: arid, arlen, arvalid/arready
//   r*                  read data: rid, rdata, rresp, rlast, rvalid/rready
//   ingress_*           core-side pop port of the AXI-W -> core FIFO (+ level)
//   egress_*            core-side push port of the core -> AXI-R FIFO (+ level)
// ---------------------------------------------------------------------------

// First-word-fall-through FIFO. The head word shows on dout whenever the
// FIFO is not empty. The parent drives push only when !full and pop only
// when !empty.
module simon_axi_fifo_bridge_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 512,
    parameter int LW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge value, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;   // idle, or push+pop together
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset. Resetting the
    // pointers and the level is enough to empty the FIFO. A reset on the
    // array would stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
endmodule

module simon_axi_fifo_bridge #(
    parameter  int DATA_WIDTH = 128,
    parameter  int LEN_WIDTH  = 8,
    parameter  int ID_WIDTH   = 4,
    parameter  int FIFO_DEPTH = 512,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    // AW
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic                    awvalid,
    output logic                    awready,
    // W
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    // B
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // AR
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic                    arvalid,
    output logic                    arready,
    // R
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    // ingress (AXI W -> core)
    output logic [DATA_WIDTH-1:0]   ingress_dout,
    output logic                    ingress_vld,
    input  logic                    ingress_rdy,
    output logic [LW-1:0]           ingress_level,
    // egress (core -> AXI R)
    input  logic [DATA_WIDTH-1:0]   egress_din,
    input  logic                    egress_vld,
    output logic                    egress_rdy,
    output logic [LW-1:0]           egress_level
);
    localparam int NB = DATA_WIDTH / 8;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ---------------- FIFOs ----------------
    logic                  ing_full, ing_empty, ing_push, ing_pop;
    logic                  eg_full, eg_empty, eg_push, eg_pop;
    logic [DATA_WIDTH-1:0] w_masked;
    logic [DATA_WIDTH-1:0] eg_dout;

    simon_axi_fifo_bridge_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .LW         (LW)
    ) u_ingress (
        .clk   (clk),
        .rst   (rst),
        .push  (ing_push),
        .din   (w_masked),
        .pop   (ing_pop),
        .dout  (ingress_dout),
        .level (ingress_level),
        .full  (ing_full),
        .empty (ing_empty)
    );

    simon_axi_fifo_bridge_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .LW         (LW)
    ) u_egress (
        .clk   (clk),
        .rst   (rst),
        .push  (eg_push),
        .din   (egress_din),
        .pop   (eg_pop),
        .dout  (eg_dout),
        .level (egress_level),
        .full  (eg_full),
        .empty (eg_empty)
    );

    assign ingress_vld = !ing_empty;
    assign ing_pop     = ingress_vld & ingress_rdy;
    assign egress_rdy  = !eg_full;
    assign eg_push     = egress_vld & egress_rdy;

    // ---------------- write path ----------------
    logic [1:0]           w_state;
    logic [ID_WIDTH-1:0]  aw_id_q;
    logic [LEN_WIDTH-1:0] aw_len_q;
    logic [LEN_WIDTH-1:0] w_cnt;
    logic                 w_err;
    logic                 w_beat;
    logic                 w_final;
    logic                 strb_full;

    // Bytes with a cleared strobe go into the FIFO as zero. Stale bus data
    // never reaches the core.
    // NOTE: an always_comb block assigns every output on every path, here
    // with a default before the loop. A path with no assignment infers a latch.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < NB; i++) begin
            if (wstrb[i]) w_masked[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    assign strb_full = &wstrb;
    assign awready   = (w_state == W_IDLE);
    assign wready    = (w_state == W_DATA) && !ing_full;
    assign w_beat    = wvalid & wready;
    assign ing_push  = w_beat;
    // The burst length comes from the captured awlen. wlast is only checked
    // against it for consistency.
    assign w_final   = (w_cnt == aw_len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            aw_id_q  <= '0;
            aw_len_q <= '0;
            w_cnt    <= '0;
            w_err    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid) begin
                        aw_id_q  <= awid;
                        aw_len_q <= awlen;
                        w_cnt    <= '0;
                        w_err    <= 1'b0;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        // The counter wraps only on the final beat of a
                        // maximum-length burst, after the burst has ended.
                        w_cnt <= w_cnt + 1'b1;
                        if (!strb_full || (wlast != w_final)) w_err <= 1'b1;
                        if (w_final) w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign bvalid = (w_state == W_RESP);
    assign bid    = aw_id_q;
    assign bresp  = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read path ----------------
    logic [0:0]           r_state;
    logic [ID_WIDTH-1:0]  ar_id_q;
    logic [LEN_WIDTH-1:0] ar_len_q;
    logic [LEN_WIDTH-1:0] r_cnt;

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA) && !eg_empty;
    assign rdata   = eg_dout;
    assign rid     = ar_id_q;
    assign rresp   = RESP_OKAY;
    assign rlast   = (r_state == R_DATA) && (r_cnt == ar_len_q);
    assign eg_pop  = rvalid & rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            ar_id_q  <= '0;
            ar_len_q <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        ar_id_q  <= arid;
                        ar_len_q <= arlen;
                        r_cnt    <= '0;
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (eg_pop) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (rlast) r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simon_axi_fifo_bridge.sv
// ---------------------------------------------------------------------------
// tb_simon_axi_fifo_bridge
//
// Purpose: self-checking bench for simon_axi_fifo_bridge at its default
// parameters. A table of write-burst records covers the response codes and
// the strobe masking. Hand-written sequences cover FIFO-full backpressure,
// read bursts under rready toggling, concurrent read/write and reset in the
// middle of a burst. Inputs change 1 time unit after a rising edge, and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_simon_axi_fifo_bridge;
    localparam int DW  = 128;
    localparam int SW  = DW / 8;
    localparam int LW  = 10;
    localparam int TMO = 3000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     awid = '0;
    logic [7:0]     awlen = '0;
    logic           awvalid = 1'b0;
    logic           awready;
    logic [DW-1:0]  wdata = '0;
    logic [SW-1:0]  wstrb = '0;
    logic           wlast = 1'b0;
    logic           wvalid = 1'b0;
    logic           wready;
    logic [3:0]     bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready = 1'b0;
    logic [3:0]     arid = '0;
    logic [7:0]     arlen = '0;
    logic           arvalid = 1'b0;
    logic           arready;
    logic [3:0]     rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready = 1'b0;
    logic [DW-1:0]  ingress_dout;
    logic           ingress_vld;
    logic           ingress_rdy = 1'b0;
    logic [LW-1:0]  ingress_level;
    logic [DW-1:0]  egress_din = '0;
    logic           egress_vld = 1'b0;
    logic           egress_rdy;
    logic [LW-1:0]  egress_level;

    simon_axi_fifo_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .awid          (awid),
        .awlen         (awlen),
        .awvalid       (awvalid),
        .awready       (awready),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wlast         (wlast),
        .wvalid        (wvalid),
        .wready        (wready),
        .bid           (bid),
        .bresp         (bresp),
        .bvalid        (bvalid),
        .bready        (bready),
        .arid          (arid),
        .arlen         (arlen),
        .arvalid       (arvalid),
        .arready       (arready),
        .rid           (rid),
        .rdata         (rdata),
        .rresp         (rresp),
        .rlast         (rlast),
        .rvalid        (rvalid),
        .rready        (rready),
        .ingress_dout  (ingress_dout),
        .ingress_vld   (ingress_vld),
        .ingress_rdy   (ingress_rdy),
        .ingress_level (ingress_level),
        .egress_din    (egress_din),
        .egress_vld    (egress_vld),
        .egress_rdy    (egress_rdy),
        .egress_level  (egress_level)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] ing_q [$];   // expected ingress words, in order
    logic [DW-1:0] eg_q  [$];   // words pushed into egress, in order
    logic [3:0]    got_bid;
    logic [1:0]    got_bresp;

    typedef struct {
        logic [3:0]    id;
        logic [7:0]    len;
        int            wlast_beat;    // beat index carrying wlast, -1 = none
        int            partial_beat;  // beat using pstrb, -1 = none
        logic [SW-1:0] pstrb;
        logic [1:0]    exp_resp;
        logic [LW-1:0] exp_level;
    } wvec_t;

    wvec_t vecs [6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: handshake timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mask_word(input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < SW; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] mk_word(input logic [31:0] tag);
        return {tag ^ 32'hFFFF_0000, tag + 32'd3, ~tag, tag};
    endfunction

    task automatic send_aw(input logic [3:0] id, input logic [7:0] len);
        int t;
        t = 0;
        awid = id; awlen = len; awvalid = 1'b1;
        @(negedge clk);
        while (!awready) begin
            if (++t > TMO) begin timeout_fail("aw_handshake"); break; end
            @(negedge clk);
        end
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [7:0] len);
        int t;
        t = 0;
        arid = id; arlen = len; arvalid = 1'b1;
        @(negedge clk);
        while (!arready) begin
            if (++t > TMO) begin timeout_fail("ar_handshake"); break; end
            @(negedge clk);
        end
        tick();
        arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
        int t;
        t = 0;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        @(negedge clk);
        while (!wready) begin
            if (++t > TMO) begin timeout_fail("w_handshake"); break; end
            @(negedge clk);
        end
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        ing_q.push_back(mask_word(d, s));
    endtask

    task automatic recv_b();
        int t;
        t = 0;
        bready = 1'b1;
        @(negedge clk);
        while (!bvalid) begin
            if (++t > TMO) begin timeout_fail("b_handshake"); break; end
            @(negedge clk);
        end
        got_bid = bid; got_bresp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [7:0] len, input int wl_beat,
                               input int p_beat, input logic [SW-1:0] pstrb);
        send_aw(id, len);
        for (int b = 0; b <= int'(len); b++) begin
            send_w(mk_word({4'hD, id, len, 8'h00, 8'(b)} + 32'(b)),
                   (b == p_beat) ? pstrb : {SW{1'b1}}, b == wl_beat);
        end
    endtask

    task automatic drain_ing(input int n);
        int got, t;
        got = 0; t = 0;
        ingress_rdy = 1'b1;
        while (got < n) begin
            @(negedge clk);
            if (ingress_vld) begin
                if (ing_q.size() == 0) begin
                    timeout_fail("ingress_unexpected_word");
                end else begin
                    check("ingress_data", ingress_dout, ing_q.pop_front());
                end
                got++;
            end else if (++t > TMO) begin
                timeout_fail("ingress_drain");
                break;
            end
        end
        tick();
        ingress_rdy = 1'b0;
    endtask

    task automatic push_eg(input logic [DW-1:0] d);
        int t;
        t = 0;
        egress_din = d; egress_vld = 1'b1;
        @(negedge clk);
        while (!egress_rdy) begin
            if (++t > TMO) begin timeout_fail("egress_push"); break; end
            @(negedge clk);
        end
        tick();
        egress_vld = 1'b0;
        eg_q.push_back(d);
    endtask

    // With toggle set, rready alternates 0/1, so held beats are checked
    // against the same expected word on the stall cycles.
    task automatic read_burst(input logic [3:0] id, input logic [7:0] len, input logic toggle);
        int beat, cyc;
        beat = 0; cyc = 0;
        send_ar(id, len);
        while (beat <= int'(len)) begin
            rready = toggle ? cyc[0] : 1'b1;
            @(negedge clk);
            if (rvalid) begin
                check("r_data", rdata, (eg_q.size() != 0) ? eg_q[0] : '0);
                check("r_id", DW'(rid), DW'(id));
                check("r_last", DW'(rlast), DW'(beat == int'(len)));
                check("r_resp", DW'(rresp), DW'(2'b00));
                if (rready) begin
                    if (eg_q.size() != 0) void'(eg_q.pop_front());
                    beat++;
                end
            end
            tick();
            if (++cyc > TMO) begin timeout_fail("r_burst"); break; end
        end
        rready = 1'b0;
        check("r_idle_rvalid", DW'(rvalid), DW'(1'b0));
        check("r_idle_arready", DW'(arready), DW'(1'b1));
    endtask

    initial begin
        // {id, len, wlast beat, partial beat, partial strobe, bresp, level}
        vecs[0] = '{4'd5,  8'd3, 3,  -1, 16'hFFFF, 2'b00, 10'd4};  // clean 4 beats
        vecs[1] = '{4'd2,  8'd1, 0,  -1, 16'hFFFF, 2'b10, 10'd2};  // early wlast
        vecs[2] = '{4'd7,  8'd1, 1,  0,  16'h00FF, 2'b10, 10'd2};  // partial strobe
        vecs[3] = '{4'd1,  8'd0, 0,  -1, 16'hFFFF, 2'b00, 10'd1};  // single beat
        vecs[4] = '{4'd3,  8'd2, -1, -1, 16'hFFFF, 2'b10, 10'd3};  // wlast missing
        vecs[5] = '{4'd15, 8'd0, 0,  0,  16'h0000, 2'b10, 10'd1};  // empty strobe

        // ---- reset state ----
        repeat (3) tick();
        rst = 1'b0;
        check("rst_awready", DW'(awready), DW'(1'b1));
        check("rst_arready", DW'(arready), DW'(1'b1));
        check("rst_wready", DW'(wready), DW'(1'b0));
        check("rst_bvalid", DW'(bvalid), DW'(1'b0));
        check("rst_rvalid", DW'(rvalid), DW'(1'b0));
        check("rst_rlast", DW'(rlast), DW'(1'b0));
        check("rst_ingress_vld", DW'(ingress_vld), DW'(1'b0));
        check("rst_egress_rdy", DW'(egress_rdy), DW'(1'b1));
        check("rst_bresp", DW'(bresp), DW'(2'b00));
        check("rst_rresp", DW'(rresp), DW'(2'b00));
        check("rst_bid", DW'(bid), DW'(4'd0));
        check("rst_rid", DW'(rid), DW'(4'd0));
        check("rst_ingress_level", DW'(ingress_level), DW'(10'd0));
        check("rst_egress_level", DW'(egress_level), DW'(10'd0));

        // ---- table-driven write bursts ----
        for (int v = 0; v < 6; v++) begin
            write_burst(vecs[v].id, vecs[v].len, vecs[v].wlast_beat, vecs[v].partial_beat, vecs[v].pstrb);
            check("w_bvalid_after_last", DW'(bvalid), DW'(1'b1));
            check("w_ingress_level", DW'(ingress_level), DW'(vecs[v].exp_level));
            check("w_awready_in_resp", DW'(awready), DW'(1'b0));
            tick();
            check("w_bvalid_held", DW'(bvalid), DW'(1'b1));
            recv_b();
            check("w_bid", DW'(got_bid), DW'(vecs[v].id));
            check("w_bresp", DW'(got_bresp), DW'(vecs[v].exp_resp));
            check("w_bvalid_cleared", DW'(bvalid), DW'(1'b0));
            check("w_awready_idle", DW'(awready), DW'(1'b1));
            drain_ing(int'(vecs[v].len) + 1);
        end

        // ---- fill ingress to FIFO_DEPTH with two max-length bursts ----
        for (int k = 0; k < 2; k++) begin
            write_burst(4'd6, 8'd255, 255, -1, 16'hFFFF);
            recv_b();
            check("fill_bresp", DW'(got_bresp), DW'(2'b00));
        end
        check("fill_level", DW'(ingress_level), DW'(10'd512));
        send_aw(4'd4, 8'd0);
        @(negedge clk);
        check("full_wready", DW'(wready), DW'(1'b0));
        tick();
        check("full_wready_held", DW'(wready), DW'(1'b0));
        check("full_head", ingress_dout, ing_q[0]);
        ingress_rdy = 1'b1;
        tick();
        ingress_rdy = 1'b0;
        void'(ing_q.pop_front());
        check("pop_wready", DW'(wready), DW'(1'b1));
        check("pop_level", DW'(ingress_level), DW'(10'd511));
        send_w(mk_word(32'hC0FFEE00), 16'hFFFF, 1'b1);
        recv_b();
        check("refill_bid", DW'(got_bid), DW'(4'd4));
        check("refill_bresp", DW'(got_bresp), DW'(2'b00));
        drain_ing(512);
        check("drained_level", DW'(ingress_level), DW'(10'd0));

        // ---- read burst with rready toggling ----
        for (int i = 0; i < 3; i++) push_eg(mk_word(32'h5E00_0000 + 32'(i)));
        check("eg_level3", DW'(egress_level), DW'(10'd3));
        @(negedge clk);
        check("r_idle_no_rvalid", DW'(rvalid), DW'(1'b0));
        tick();
        read_burst(4'd9, 8'd2, 1'b1);
        check("eg_level_after_read", DW'(egress_level), DW'(10'd0));

        // ---- concurrent 16-beat write and 16-beat read ----
        fork
            begin
                write_burst(4'd11, 8'd15, 15, -1, 16'hFFFF);
                recv_b();
                check("conc_bid", DW'(got_bid), DW'(4'd11));
                check("conc_bresp", DW'(got_bresp), DW'(2'b00));
            end
            drain_ing(16);
            for (int i = 0; i < 16; i++) push_eg(mk_word(32'h77AA_0000 + 32'(i)));
            read_burst(4'd12, 8'd15, 1'b0);
        join
        check("conc_ing_level", DW'(ingress_level), DW'(10'd0));
        check("conc_eg_level", DW'(egress_level), DW'(10'd0));

        // ---- reset during beat 2 of a 4-beat write ----
        send_aw(4'd5, 8'd3);
        send_w(mk_word(32'h1111_0000), 16'hFFFF, 1'b0);
        wdata = mk_word(32'h1111_0001); wstrb = '1; wvalid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; wvalid = 1'b0;
        ing_q.delete();
        check("rstmid_bvalid", DW'(bvalid), DW'(1'b0));
        check("rstmid_level", DW'(ingress_level), DW'(10'd0));
        check("rstmid_awready", DW'(awready), DW'(1'b1));
        check("rstmid_wready", DW'(wready), DW'(1'b0));
        repeat (3) tick();
        check("rstmid_no_b_later", DW'(bvalid), DW'(1'b0));
        write_burst(4'd8, 8'd0, 0, -1, 16'hFFFF);
        recv_b();
        check("post_rst_bid", DW'(got_bid), DW'(4'd8));
        check("post_rst_bresp", DW'(got_bresp), DW'(2'b00));
        drain_ing(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/simon_axi_fifo_bridge.md
SIMON_AXI_FIFO_BRIDGE -- requirements
Module: simon_axi_fifo_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: AXI data and FIFO word width; multiple of 8.
REQ-002 SHALL have parameter LEN_WIDTH, default 8: width of awlen and arlen.
REQ-003 SHALL have parameter ID_WIDTH, default 4: width of the AXI ID fields.
REQ-004 SHALL have parameter FIFO_DEPTH, default 512: words per internal FIFO; power of two, at least 4; LW = clog2(FIFO_DEPTH)+1.
REQ-005 SHALL have ports clk in 1, clock; rst in 1, reset. Reset is synchronous and active-high.
REQ-006 SHALL have AW ports: awid in ID_WIDTH; awlen in LEN_WIDTH; awvalid in 1; awready out 1.
REQ-007 SHALL have W ports: wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1.
REQ-008 SHALL have B ports: bid out ID_WIDTH; bresp out 2; bvalid out 1; bready in 1.
REQ-009 SHALL have AR ports: arid in ID_WIDTH; arlen in LEN_WIDTH; arvalid in 1; arready out 1.
REQ-010 SHALL have R ports: rid out ID_WIDTH; rdata out DATA_WIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1.
REQ-011 SHALL have ingress ports: ingress_dout out DATA_WIDTH; ingress_vld out 1; ingress_rdy in 1; ingress_level out LW.
REQ-012 SHALL have egress ports: egress_din in DATA_WIDTH; egress_vld in 1; egress_rdy out 1; egress_level out LW.
REQ-013 SHALL NOT port AXI address, burst, size, cache, lock, prot, qos or region fields; the address is a don't-care.

Function
REQ-014 SHALL contain two internal first-word-fall-through FIFOs of FIFO_DEPTH words: ingress (AXI W to core) and egress (core to AXI R).
REQ-015 Each FIFO SHALL assert full when level==FIFO_DEPTH and vld when level!=0; a push into an empty FIFO SHALL appear at the output on the next cycle.
REQ-016 A push and a pop in the same cycle SHALL leave the level unchanged; a push while full SHALL be impossible because ready = !full.
REQ-017 egress_rdy SHALL equal !egress_full; a push occurs on egress_vld & egress_rdy.
REQ-018 ingress_vld SHALL equal !ingress_empty; a pop occurs on ingress_vld & ingress_rdy.
REQ-019 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP. In W_IDLE, awready=1; on awvalid it SHALL capture awid and awlen, clear the beat counter and the error flag, and go to W_DATA.
REQ-020 In W_DATA, wready SHALL equal !ingress_full; each wvalid & wready beat SHALL push the wdata bytes with wstrb=1, push zero in bytes with wstrb=0, and increment the beat counter.
REQ-021 The write burst SHALL end on the beat where the counter equals the captured awlen (awlen+1 beats total); the FSM then goes to W_RESP.
REQ-022 The error flag SHALL set on any beat with a partial wstrb, on any earlier beat carrying wlast=1, or on a final beat with wlast=0.
REQ-023 In W_RESP, bvalid=1, bid=captured awid, and bresp=2'b10 (SLVERR) if the error flag is set, else 2'b00. bvalid/bid/bresp SHALL hold until bready, then the FSM returns to W_IDLE.
REQ-024 awready and wready SHALL be 0 in all states other than those stated above.
REQ-025 Read FSM SHALL have states R_IDLE, R_DATA. In R_IDLE, arready=1; on arvalid it SHALL capture arid and arlen, clear the read beat counter, and go to R_DATA.
REQ-026 In R_DATA, rvalid SHALL equal !egress_empty; rdata = egress head; rid = captured arid; rresp=2'b00; rlast=1 when the counter equals the captured arlen.
REQ-027 Each rvalid & rready SHALL pop egress and increment the counter; rlast & rvalid & rready SHALL return the FSM to R_IDLE.
REQ-028 rvalid SHALL be 0 in R_IDLE regardless of egress content; rdata/rid/rlast SHALL be stable while rvalid=1 and rready=0.
REQ-029 The read and write FSMs SHALL operate fully independently and concurrently.
REQ-030 Beat counters SHALL be LEN_WIDTH bits; awlen/arlen = 2^LEN_WIDTH-1 SHALL work without wrap error.

Reset
REQ-031 While rst=1 on a clk edge: both FSMs to idle, both FIFOs emptied, levels 0, counters and error flag 0.
REQ-032 After reset, outputs SHALL be: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, ingress_vld=0, egress_rdy=1, bresp=0, rresp=0, bid=0, rid=0.
REQ-033 Reset mid-burst SHALL abandon the burst with no B response and discard FIFO contents.

Verification
REQ-034 awlen=3, awid=5, 4 beats with full wstrb and wlast on beat 4 -> ingress_level 4; bvalid 1 cycle after the last beat; bid=5, bresp=00.
REQ-035 awlen=1, wlast on beat 1 -> bresp=10; a beat with wstrb=16'h00FF -> that word's upper 8 bytes are 0 and bresp=10.
REQ-036 Fill ingress with FIFO_DEPTH beats while ingress_rdy=0 -> wready=0 at level FIFO_DEPTH; one pop -> wready=1 the next cycle.
REQ-037 Push 3 egress words, then arlen=2, arid=9 -> 3 R beats in order, rid=9, rlast on beat 3 only; rready toggling holds the data stable.
REQ-038 A concurrent 16-beat write and 16-beat read -> both complete, with no beat lost or reordered.
REQ-039 Assert rst during beat 2 of a 4-beat write -> no bvalid, ingress_level=0, awready=1 the cycle after reset.
